// File: rtl/rom_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : rom_arbiter_if
// Description : Bundles the two requester ports, the ROM pin group and the
//               busy flag of rom_arbiter. The slave modport is the arbiter's
//               view. The master modport is the view of the surrounding
//               requesters and ROM.
// Revision    : 1.0 - initial release
// ============================================================================
interface rom_arbiter_if;
    // requester 0
    logic       req0;
    logic [3:0] addr0;
    logic       ack0;
    logic [3:0] data0;
    // requester 1
    logic       req1;
    logic [3:0] addr1;
    logic       ack1;
    logic [3:0] data1;
    // ROM pins
    logic       rom_ce_n;
    logic       rom_oe_n;
    logic [3:0] rom_addr;
    logic [3:0] rom_data;
    // status
    logic       busy;

    modport slave (
        input  req0, addr0, req1, addr1, rom_data,
        output ack0, data0, ack1, data1, rom_ce_n, rom_oe_n, rom_addr, busy
    );

    modport master (
        output req0, addr0, req1, addr1, rom_data,
        input  ack0, data0, ack1, data1, rom_ce_n, rom_oe_n, rom_addr, busy
    );
endinterface
`default_nettype wire

// File: rtl/rom_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rom_arbiter
// Description : Two-port arbiter and access sequencer for a 16x4
//               asynchronous ROM. For each grant it runs a setup, access and
//               release sequence on the active-low ROM pins. It registers the
//               returned nibble and returns it to the winner with a one-cycle
//               acknowledge.
//               Build option: define ROM_ARB_FIXED_PRIO_EN to replace the
//               round-robin arbitration with fixed priority. Under fixed
//               priority, port 0 always wins a tie.
// Revision    : 1.0 - initial release
// ============================================================================
module rom_arbiter #(
    parameter int ACCESS_CYCLES = 1      // cycles rom_oe_n is low, 1..15
) (
    input  wire logic    clk,
    input  wire logic    rst,
    rom_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic [3:0] c_CNT_LOAD = 4'(ACCESS_CYCLES - 1);

    state_t     r_state;
    state_t     w_state_nxt;
    logic       w_start;
    logic       w_grant;
    logic       r_cur;
    logic       r_last;
    logic [3:0] r_cnt;
    logic [3:0] r_addr;
    logic       r_ce_n;
    logic       r_oe_n;
    logic       r_ack0;
    logic       r_ack1;
    logic [3:0] r_data0;
    logic [3:0] r_data1;
    logic       r_busy;

    // Arbitration: pick the winner among the pending requests.
`ifdef ROM_ARB_FIXED_PRIO_EN
    always_comb begin
        w_grant = bus.req0 ? 1'b0 : 1'b1;
    end
`else
    always_comb begin
        w_grant = 1'b0;
        if (bus.req0 && bus.req1) begin
            w_grant = ~r_last;
        end else begin
            w_grant = ~bus.req0;
        end
    end
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic. DONE always returns to IDLE, even if a request is still high.
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.req0 || bus.req1) begin
                    w_start     = 1'b1;
                    w_state_nxt = ST_SETUP;
                end
            end
            ST_SETUP:  w_state_nxt = ST_ACCESS;
            ST_ACCESS: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE:   w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // Datapath and registered outputs. The pin and ack values are derived from the next state, so they are valid in that state's cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cur   <= 1'b0;
            r_last  <= 1'b1;
            r_cnt   <= 4'd0;
            r_addr  <= 4'd0;
            r_ce_n  <= 1'b1;
            r_oe_n  <= 1'b1;
            r_ack0  <= 1'b0;
            r_ack1  <= 1'b0;
            r_data0 <= 4'd0;
            r_data1 <= 4'd0;
            r_busy  <= 1'b0;
        end else begin
            if (w_start) begin
                r_cur  <= w_grant;
                r_addr <= w_grant ? bus.addr1 : bus.addr0;
            end
            if (r_state == ST_SETUP) begin
                r_cnt <= c_CNT_LOAD;
            end else if (r_state == ST_ACCESS && r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (r_state == ST_ACCESS && r_cnt == 4'd0) begin
                if (r_cur) begin
                    r_data1 <= bus.rom_data;
                end else begin
                    r_data0 <= bus.rom_data;
                end
            end
            if (r_state == ST_DONE) begin
                r_last <= r_cur;
            end
            r_ce_n <= !(w_state_nxt == ST_SETUP || w_state_nxt == ST_ACCESS);
            r_oe_n <= (w_state_nxt != ST_ACCESS);
            r_ack0 <= (w_state_nxt == ST_DONE) && !r_cur;
            r_ack1 <= (w_state_nxt == ST_DONE) &&  r_cur;
            r_busy <= (w_state_nxt != ST_IDLE);
        end
    end

    assign bus.rom_addr = r_addr;
    assign bus.rom_ce_n = r_ce_n;
    assign bus.rom_oe_n = r_oe_n;
    assign bus.ack0     = r_ack0;
    assign bus.ack1     = r_ack1;
    assign bus.data0    = r_data0;
    assign bus.data1    = r_data1;
    assign bus.busy     = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_rom_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_rom_arbiter
// Description : Directed self-checking bench for rom_arbiter. Instance u_a
//               uses the default ACCESS_CYCLES. Instance u_b uses
//               ACCESS_CYCLES=3. Each instance drives a behavioural ROM
//               that returns data only while CE and OE are both low.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rom_arbiter;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    rom_arbiter_if bus_a ();
    rom_arbiter_if bus_b ();

    rom_arbiter #(.ACCESS_CYCLES(1)) u_a (.clk(clk), .rst(rst), .bus(bus_a.slave));
    rom_arbiter #(.ACCESS_CYCLES(3)) u_b (.clk(clk), .rst(rst), .bus(bus_b.slave));

    // ROM contents: the listed words are fixed, and every other word is the inverted address
    function automatic logic [3:0] rom_word(input logic [3:0] a);
        case (a)
            4'd2:    rom_word = 4'b0100;
            4'd3:    rom_word = 4'b0110;
            4'd5:    rom_word = 4'b1010;
            4'd8:    rom_word = 4'b0001;
            4'd15:   rom_word = 4'b1111;
            default: rom_word = ~a;
        endcase
    endfunction

    assign bus_a.rom_data = (!bus_a.rom_ce_n && !bus_a.rom_oe_n) ? rom_word(bus_a.rom_addr) : 4'h0;
    assign bus_b.rom_data = (!bus_b.rom_ce_n && !bus_b.rom_oe_n) ? rom_word(bus_b.rom_addr) : 4'h0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        bus_a.req0 = 1'b0; bus_a.addr0 = 4'd0; bus_a.req1 = 1'b0; bus_a.addr1 = 4'd0;
        bus_b.req0 = 1'b0; bus_b.addr0 = 4'd0; bus_b.req1 = 1'b0; bus_b.addr1 = 4'd0;
        tick();
        tick();

        // ---- reset state
        chk("rst_ce_n",  {3'b0, bus_a.rom_ce_n}, 4'd1);
        chk("rst_oe_n",  {3'b0, bus_a.rom_oe_n}, 4'd1);
        chk("rst_addr",  bus_a.rom_addr, 4'd0);
        chk("rst_ack",   {2'b0, bus_a.ack1, bus_a.ack0}, 4'd0);
        chk("rst_data0", bus_a.data0, 4'd0);
        chk("rst_data1", bus_a.data1, 4'd0);
        chk("rst_busy",  {3'b0, bus_a.busy}, 4'd0);
        chk("rst_b_busy", {3'b0, bus_b.busy}, 4'd0);

        // ---- single read, addr 5, cycle 0 = this cycle
        rst = 1'b0;
        bus_a.req0 = 1'b1; bus_a.addr0 = 4'd5;
        for (int c = 1; c <= 4; c++) begin
            tick();
            chk($sformatf("sr_ce_n_c%0d", c), {3'b0, bus_a.rom_ce_n}, (c == 1 || c == 2) ? 4'd0 : 4'd1);
            chk($sformatf("sr_oe_n_c%0d", c), {3'b0, bus_a.rom_oe_n}, (c == 2) ? 4'd0 : 4'd1);
            chk($sformatf("sr_ack0_c%0d", c), {3'b0, bus_a.ack0},     (c == 3) ? 4'd1 : 4'd0);
            chk($sformatf("sr_busy_c%0d", c), {3'b0, bus_a.busy},     (c <= 3) ? 4'd1 : 4'd0);
            if (c == 1) chk("sr_rom_addr", bus_a.rom_addr, 4'd5);
            if (c == 3) begin
                chk("sr_data0", bus_a.data0, 4'b1010);
                bus_a.req0 = 1'b0;
            end
        end
        chk("sr_ack1_never", {3'b0, bus_a.ack1}, 4'd0);

        // ---- ACCESS_CYCLES=3 on instance b: req1, addr1=3
        bus_b.req1 = 1'b1; bus_b.addr1 = 4'd3;
        for (int c = 1; c <= 6; c++) begin
            tick();
            chk($sformatf("ac3_oe_n_c%0d", c), {3'b0, bus_b.rom_oe_n}, (c >= 2 && c <= 4) ? 4'd0 : 4'd1);
            chk($sformatf("ac3_ce_n_c%0d", c), {3'b0, bus_b.rom_ce_n}, (c >= 1 && c <= 4) ? 4'd0 : 4'd1);
            chk($sformatf("ac3_ack1_c%0d", c), {3'b0, bus_b.ack1},     (c == 5) ? 4'd1 : 4'd0);
            if (c == 5) begin
                chk("ac3_data1", bus_b.data1, 4'b0110);
                bus_b.req1 = 1'b0;
            end
        end
        chk("ac3_data0_untouched", bus_b.data0, 4'd0);

        // ---- simultaneous requests held 16 cycles, after a fresh reset
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus_a.req0 = 1'b1; bus_a.addr0 = 4'd8;
        bus_a.req1 = 1'b1; bus_a.addr1 = 4'd15;
        for (int c = 1; c <= 15; c++) begin
            tick();
`ifdef ROM_ARB_FIXED_PRIO_EN
            chk($sformatf("sat_ack0_c%0d", c), {3'b0, bus_a.ack0}, (c % 4 == 3) ? 4'd1 : 4'd0);
            chk($sformatf("sat_ack1_c%0d", c), {3'b0, bus_a.ack1}, 4'd0);
`else
            chk($sformatf("sat_ack0_c%0d", c), {3'b0, bus_a.ack0}, (c == 3 || c == 11) ? 4'd1 : 4'd0);
            chk($sformatf("sat_ack1_c%0d", c), {3'b0, bus_a.ack1}, (c == 7 || c == 15) ? 4'd1 : 4'd0);
            if (c == 7) begin
                chk("sim_data1", bus_a.data1, 4'b1111);
                chk("sim_data0_held", bus_a.data0, 4'b0001);
            end
`endif
            if (c == 3) chk("sim_data0", bus_a.data0, 4'b0001);
        end
        bus_a.req0 = 1'b0;
        bus_a.req1 = 1'b0;
        tick();
        chk("sat_idle_busy", {3'b0, bus_a.busy}, 4'd0);

        // ---- reset mid-access: data registers currently hold nonzero words
        bus_a.req0 = 1'b1; bus_a.addr0 = 4'd5;
        tick();
        tick();
        chk("mid_in_access_oe_n", {3'b0, bus_a.rom_oe_n}, 4'd0);
        rst = 1'b1;
        bus_a.req0 = 1'b0;
        tick();
        chk("mid_ce_n",  {3'b0, bus_a.rom_ce_n}, 4'd1);
        chk("mid_oe_n",  {3'b0, bus_a.rom_oe_n}, 4'd1);
        chk("mid_busy",  {3'b0, bus_a.busy}, 4'd0);
        chk("mid_ack",   {2'b0, bus_a.ack1, bus_a.ack0}, 4'd0);
        chk("mid_data0", bus_a.data0, 4'd0);
        chk("mid_data1", bus_a.data1, 4'd0);

        // ---- address change after grant
        rst = 1'b0;
        bus_a.req0 = 1'b1; bus_a.addr0 = 4'd2;
        tick();
        bus_a.addr0 = 4'd9;
        chk("adr_setup", bus_a.rom_addr, 4'd2);
        tick();
        chk("adr_access", bus_a.rom_addr, 4'd2);
        tick();
        chk("adr_ack0", {3'b0, bus_a.ack0}, 4'd1);
        chk("adr_done", bus_a.rom_addr, 4'd2);
        chk("adr_data0", bus_a.data0, 4'b0100);
        bus_a.req0 = 1'b0;
        tick();
        chk("adr_ack0_pulse", {3'b0, bus_a.ack0}, 4'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
